channel_serializer: RTL and testbench

CHANNEL_SERIALIZER -- requirements
Module: channel_serializer

---
 rtl/channel_serializer.sv | 110 +++++++++++
 tb/tb_channel_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/channel_serializer.sv
// Captures a bank of channel words and streams the first n of them, in ascending or
// descending order, over a valid/ready beat interface. rd_sel gives a registered peek into the bank.
module channel_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_CH     = 10,
    parameter int unsigned SEL_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_bus,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [SEL_WIDTH-1:0]         num_act,
    input  logic                         rev,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [SEL_WIDTH-1:0]         out_idx,
    input  logic [SEL_WIDTH-1:0]         rd_sel,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    localparam logic [SEL_WIDTH-1:0] NumChSel = SEL_WIDTH'(NUM_CH);
    localparam logic [SEL_WIDTH-1:0] OneSel   = SEL_WIDTH'(1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] bank_q [NUM_CH];
    logic [SEL_WIDTH-1:0]  cnt_q;
    logic [SEL_WIDTH-1:0]  idx_q, idx_d;
    logic                  rev_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] beat_mux, rd_mux;
    logic [SEL_WIDTH-1:0]  n_load;
    logic                  load_fire, is_last;

    // load_ready drops combinationally with rst so nothing is accepted during reset
    assign load_ready = (state_q == StIdle) && !rst;
    assign load_fire  = load_valid && load_ready;
    assign n_load     = (num_act == '0 || num_act > NumChSel) ? NumChSel : num_act;
    assign is_last    = rev_q ? (idx_q == OneSel) : (idx_q == cnt_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (load_fire) begin
                    state_d = StStream;
                    idx_d   = rev ? n_load : OneSel;
                end
            end
            StStream: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = rev_q ? idx_q - OneSel : idx_q + OneSel;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // 1-based selects; anything outside 1..NUM_CH falls through to zero
    always_comb begin
        beat_mux = '0;
        rd_mux   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            if (idx_q == SEL_WIDTH'(k)) beat_mux = bank_q[k-1];
            if (rd_sel == SEL_WIDTH'(k)) rd_mux = bank_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            rev_q     <= 1'b0;
            rd_data_q <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) bank_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_mux;
            if (load_fire) begin
                cnt_q <= n_load;
                rev_q <= rev;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    bank_q[k] <= in_bus[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign out_valid = (state_q == StStream);
    assign out_data  = out_valid ? beat_mux : '0;
    assign out_idx   = out_valid ? idx_q : '0;
    assign out_last  = out_valid && is_last;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_channel_serializer.sv
// Directed bench for channel_serializer: ordering, clamping, backpressure, bank peek, reset abort.
module tb_channel_serializer;

    localparam int DW = 24;
    localparam int NC = 10;
    localparam int SW = 4;

    logic             clk;
    logic             rst;
    logic [NC*DW-1:0] in_bus;
    logic             load_valid;
    logic             load_ready;
    logic [SW-1:0]    num_act;
    logic             rev;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [SW-1:0]    out_idx;
    logic [SW-1:0]    rd_sel;
    logic [DW-1:0]    rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    channel_serializer #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NC),
        .SEL_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .num_act   (num_act),
        .rev       (rev),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // channel k (1-based) carries base + k
    function automatic logic [NC*DW-1:0] mk_bus(input int base);
        logic [NC*DW-1:0] b;
        b = '0;
        for (int k = 1; k <= NC; k++) b[(k-1)*DW +: DW] = DW'(base + k);
        return b;
    endfunction

    // Called away from posedge; loads and consumes a whole stream, checking every cycle.
    task automatic stream(input int na, input int n_exp, input bit r, input int base,
                          input bit bp);
        int b;
        int cyc;
        int ei;
        in_bus     = mk_bus(base);
        num_act    = SW'(na);
        rev        = r;
        out_ready  = 1'b1;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        if (bp) begin
            // keep offering a different load during the stream; it must be ignored
            in_bus  = mk_bus(base + 500);
            num_act = SW'(3);
            rev     = ~r;
        end else begin
            load_valid = 1'b0;
        end
        b   = 1;
        cyc = 0;
        while (b <= n_exp && cyc < 200) begin
            @(negedge clk);
            ei = r ? (n_exp - b + 1) : b;
            check("valid", 32'(out_valid), 32'd1);
            check("idx", 32'(out_idx), 32'(ei));
            check("data", 32'(out_data), 32'(base + ei));
            check("last", 32'(out_last), 32'(b == n_exp));
            check("ready_in_stream", 32'(load_ready), 32'd0);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b == n_exp) load_valid = 1'b0;
            @(posedge clk);
            if (out_ready) b++;
            cyc++;
        end
        if (b <= n_exp) check("stream_timeout", 32'(b), 32'(n_exp + 1));
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(load_ready), 32'd1);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_idx", 32'(out_idx), 32'd0);
        check("idle_data", 32'(out_data), 32'd0);
        check("idle_last", 32'(out_last), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_bus     = '0;
        load_valid = 1'b0;
        num_act    = '0;
        rev        = 1'b0;
        out_ready  = 1'b1;
        rd_sel     = '0;

        #7;
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("post_rst_ready", 32'(load_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);

        // full ascending stream, num_act = 0 clamps to all channels
        stream(0, 10, 1'b0, 0, 1'b0);
        // descending subset
        stream(4, 4, 1'b1, 20, 1'b0);
        // over-range count clamps
        stream(13, 10, 1'b0, 100, 1'b0);
        // random backpressure with a competing load held high
        stream(7, 7, 1'b1, 40, 1'b1);
        stream(0, 10, 1'b0, 200, 1'b1);

        // bank peek sweep: bank holds base 200
        for (int s = 0; s < 16; s++) begin
            rd_sel = SW'(s);
            @(posedge clk);
            #1;
            check("rd_sweep", 32'(rd_data), (s >= 1 && s <= NC) ? 32'(200 + s) : 32'd0);
        end

        // reset mid-stream at beat 3
        @(negedge clk);
        in_bus     = mk_bus(60);
        num_act    = '0;
        rev        = 1'b0;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_abort_idx", 32'(out_idx), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_idx", 32'(out_idx), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_ready", 32'(load_ready), 32'd0);
        check("abort_rd", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        check("abort_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        in_bus     = mk_bus(80);
        load_valid = 1'b1;
        rd_sel     = SW'(5);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("reload_valid", 32'(out_valid), 32'd1);
        check("reload_idx", 32'(out_idx), 32'd1);
        check("reload_data", 32'(out_data), 32'd81);
        check("reload_rd_old", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        check("reload_rd_new", 32'(rd_data), 32'd85);
        for (int b = 2; b <= NC; b++) begin
            @(negedge clk);
            check("reload_beat_idx", 32'(out_idx), 32'(b));
            check("reload_beat_data", 32'(out_data), 32'(80 + b));
            check("reload_beat_last", 32'(out_last), 32'(b == NC));
            @(posedge clk);
        end
        @(negedge clk);
        check("reload_done_ready", 32'(load_ready), 32'd1);
        check("reload_done_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
